main_calc: RTL and testbench



---
 rtl/main_calc.sv | 155 +++++++++++++++
 tb/tb_main_calc.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/main_calc.sv
// -----------------------------------------------------------------------------
// main_calc -- 8-bit LIFO stack calculator datapath core.
//
// Operands are pushed onto a DEPTH-entry stack; binary opcodes pop the top two
// entries (T = top, N = entry below top) and push the 8-bit truncated result.
// A sticky error flag (valid = 0) freezes the calculator until reset.
//
// Opcodes: 0 push in, 1 pop, 2 T+N, 3 T*N, 4 T-N, 5 T/N, 6 T%N, 7 illegal.
//
// Ports:
//   in     [7:0] in  : operand for the push opcode
//   op     [2:0] in  : opcode, sampled only while apply = 1
//   apply        in  : command strobe, one command per rising clk edge
//   tail   [7:0] out : current top of stack, 0 when the stack is empty
//   valid        out : 1 = no error since reset, 0 = sticky error
//   empty        out : 1 when the stack holds no entries
//   clk          in  : rising-edge clock
//   reset        in  : synchronous active-high reset, priority over apply
//
// Parameter:
//   DEPTH        : number of stack entries (default 5)
//
// Configuration macro MAIN_CALC_DIVMOD_EN:
//   defined   -> opcodes 5 and 6 divide / take remainder, N = 0 is an error
//   undefined -> no divider is built and opcodes 5 and 6 act as illegal
// -----------------------------------------------------------------------------
module main_calc #(
  parameter int DEPTH = 5
) (
  input  logic [7:0] in,
  input  logic [2:0] op,
  input  logic       apply,
  output logic [7:0] tail,
  output logic       valid,
  output logic       empty,
  input  logic       clk,
  input  logic       reset
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    OP_PUSH = 3'd0,
    OP_POP  = 3'd1,
    OP_ADD  = 3'd2,
    OP_MUL  = 3'd3,
    OP_SUB  = 3'd4,
    OP_DIV  = 3'd5,
    OP_MOD  = 3'd6,
    OP_ILL  = 3'd7
  } op_t;

  logic [7:0]    stack [DEPTH];
  logic [CW-1:0] count;

  op_t           cmd;
  logic [7:0]    top_val;
  logic [7:0]    next_val;
  logic          err;
  logic          wr_en;
  logic [CW-1:0] wr_idx;
  logic [7:0]    result;
  logic [CW-1:0] cnt_next;

  assign cmd = op_t'(op);

  // Top and second entries; reads are guarded so an empty or single-entry
  // stack never indexes below slot 0. tail reads 0 when empty.
  always_comb begin
    top_val  = '0;
    next_val = '0;
    if (count >= CW'(1)) top_val  = stack[count - CW'(1)];
    if (count >= CW'(2)) next_val = stack[count - CW'(2)];
  end

  assign tail  = top_val;
  assign empty = (count == '0);

  // Command decode: decides whether the command is legal and, if so, which
  // slot gets written and the resulting stack depth. Binary results land in
  // the slot that held N, so the depth shrinks by one.
  always_comb begin
    err      = 1'b0;
    wr_en    = 1'b0;
    wr_idx   = '0;
    result   = '0;
    cnt_next = count;
    case (cmd)
      OP_PUSH: begin
        if (count == CW'(DEPTH)) begin
          err = 1'b1;
        end else begin
          wr_en    = 1'b1;
          wr_idx   = count;
          result   = in;
          cnt_next = count + CW'(1);
        end
      end
      OP_POP: begin
        if (count == '0) err = 1'b1;
        else             cnt_next = count - CW'(1);
      end
      OP_ADD, OP_MUL, OP_SUB: begin
        if (count < CW'(2)) begin
          err = 1'b1;
        end else begin
          wr_en    = 1'b1;
          wr_idx   = count - CW'(2);
          cnt_next = count - CW'(1);
          if (cmd == OP_ADD)      result = top_val + next_val;
          else if (cmd == OP_MUL) result = top_val * next_val;
          else                    result = top_val - next_val;
        end
      end
`ifdef MAIN_CALC_DIVMOD_EN
      OP_DIV, OP_MOD: begin
        if (count < CW'(2) || next_val == '0) begin
          err = 1'b1;
        end else begin
          wr_en    = 1'b1;
          wr_idx   = count - CW'(2);
          cnt_next = count - CW'(1);
          if (cmd == OP_DIV) result = top_val / next_val;
          else               result = top_val % next_val;
        end
      end
`else
      OP_DIV, OP_MOD: begin
        err = 1'b1;
      end
`endif
      default: begin
        err = 1'b1;
      end
    endcase
  end

  // State update: reset wins over apply; once valid drops every command is
  // ignored, and an erroring command leaves the stack untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      valid <= 1'b1;
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
    end else if (apply && valid) begin
      if (err) begin
        valid <= 1'b0;
      end else begin
        count <= cnt_next;
        if (wr_en) stack[wr_idx] <= result;
      end
    end
  end

endmodule

// File: tb/tb_main_calc.sv
// -----------------------------------------------------------------------------
// tb_main_calc -- self-checking bench for main_calc.
// A queue-based model of the stack calculator tracks the expected state; a
// compare process checks tail/empty/valid every cycle, directed sequences pin
// known results with literal values, and a random phase exercises the rest.
// -----------------------------------------------------------------------------
module tb_main_calc;

`ifdef MAIN_CALC_DIVMOD_EN
  localparam bit DIVMOD = 1'b1;
`else
  localparam bit DIVMOD = 1'b0;
`endif
  localparam int DEPTH = 5;

  logic [7:0] in;
  logic [2:0] op;
  logic       apply;
  logic [7:0] tail;
  logic       valid;
  logic       empty;
  logic       clk;
  logic       reset;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Reference model state
  int q[$];
  bit m_valid = 1'b1;

  main_calc #(.DEPTH(DEPTH)) dut (
    .in(in), .op(op), .apply(apply), .tail(tail),
    .valid(valid), .empty(empty), .clk(clk), .reset(reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison with its bookkeeping
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Calculator semantics at the level of a list of numbers
  task automatic modelStep();
    int t, n, sz;
    bit ok;
    if (reset) begin
      q.delete();
      m_valid = 1'b1;
    end else if (apply && m_valid) begin
      sz = q.size();
      ok = 1'b1;
      t = (sz >= 1) ? q[sz-1] : 0;
      n = (sz >= 2) ? q[sz-2] : 0;
      case (op)
        3'd0: if (sz >= DEPTH) ok = 1'b0; else q.push_back(int'(in));
        3'd1: if (sz == 0) ok = 1'b0; else void'(q.pop_back());
        3'd2, 3'd3, 3'd4: begin
          if (sz < 2) ok = 1'b0;
          else begin
            void'(q.pop_back());
            void'(q.pop_back());
            if (op == 3'd2)      q.push_back((t + n) % 256);
            else if (op == 3'd3) q.push_back((t * n) % 256);
            else                 q.push_back((t - n + 256) % 256);
          end
        end
        3'd5, 3'd6: begin
          if (!DIVMOD || sz < 2 || n == 0) ok = 1'b0;
          else begin
            void'(q.pop_back());
            void'(q.pop_back());
            q.push_back((op == 3'd5) ? (t / n) : (t % n));
          end
        end
        default: ok = 1'b0;
      endcase
      if (!ok) m_valid = 1'b0;
    end
  endtask

  // Drive one cycle: inputs set away from the edge, model follows the edge,
  // returns on the falling edge where outputs are stable.
  task automatic applyStimulus(input bit r, input bit a, input int o, input int d);
    reset = r;
    apply = a;
    op    = 3'(o);
    in    = 8'(d);
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model_tail",  int'(tail),  (q.size() > 0) ? q[q.size()-1] : 0);
      checkOutput("model_empty", int'(empty), (q.size() == 0) ? 1 : 0);
      checkOutput("model_valid", int'(valid), int'(m_valid));
    end
  end

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 0, 0);
  endtask

  task automatic push(input int v);
    applyStimulus(1'b0, 1'b1, 0, v);
  endtask

  initial begin
    reset = 1'b1; apply = 1'b0; op = '0; in = '0;
    @(negedge clk);
    doReset();
    check_en = 1'b1;

    // Reset state
    checkOutput("reset_tail", int'(tail), 0);
    checkOutput("reset_empty", int'(empty), 1);
    checkOutput("reset_valid", int'(valid), 1);

    // Push capacity
    push(4);
    checkOutput("cap1_tail", int'(tail), 4);
    checkOutput("cap1_empty", int'(empty), 0);
    checkOutput("cap1_valid", int'(valid), 1);
    for (int i = 0; i < 5; i++) push(4);
    checkOutput("cap6_valid", int'(valid), 0);
    checkOutput("cap6_empty", int'(empty), 0);
    checkOutput("cap6_tail", int'(tail), 4);
    doReset();
    checkOutput("cap_rst_empty", int'(empty), 1);
    checkOutput("cap_rst_valid", int'(valid), 1);

    // Hold-off
    applyStimulus(1'b0, 1'b0, 0, 4);
    applyStimulus(1'b0, 1'b0, 0, 4);
    checkOutput("hold_empty", int'(empty), 1);
    checkOutput("hold_tail", int'(tail), 0);
    checkOutput("hold_valid", int'(valid), 1);

    // Arithmetic on 4,4
    begin
      int exp_res[7];
      exp_res[2] = 8; exp_res[3] = 16; exp_res[4] = 0; exp_res[5] = 1; exp_res[6] = 0;
      for (int o = 2; o <= 6; o++) begin
        doReset();
        push(4);
        push(4);
        applyStimulus(1'b0, 1'b1, o, 0);
        if (o <= 4 || DIVMOD) begin
          checkOutput($sformatf("arith_op%0d_tail", o), int'(tail), exp_res[o]);
          checkOutput($sformatf("arith_op%0d_valid", o), int'(valid), 1);
          applyStimulus(1'b0, 1'b1, 1, 0);
          checkOutput($sformatf("arith_op%0d_pop_empty", o), int'(empty), 1);
        end else begin
          checkOutput($sformatf("nodiv_op%0d_valid", o), int'(valid), 0);
          checkOutput($sformatf("nodiv_op%0d_tail", o), int'(tail), 4);
        end
      end
    end

    // Operand order and wrap
    if (DIVMOD) begin
      doReset(); push(7); push(86);
      applyStimulus(1'b0, 1'b1, 5, 0);
      checkOutput("order_div", int'(tail), 12);
      doReset(); push(7); push(86);
      applyStimulus(1'b0, 1'b1, 6, 0);
      checkOutput("order_mod", int'(tail), 2);
      doReset(); push(0); push(86);
      applyStimulus(1'b0, 1'b1, 5, 0);
      checkOutput("divzero_valid", int'(valid), 0);
      doReset(); push(0); push(86);
      applyStimulus(1'b0, 1'b1, 6, 0);
      checkOutput("modzero_valid", int'(valid), 0);
    end
    doReset(); push(5); push(4);
    applyStimulus(1'b0, 1'b1, 4, 0);
    checkOutput("sub_wrap", int'(tail), 255);

    // Error cases
    doReset();
    applyStimulus(1'b0, 1'b1, 7, 0);
    checkOutput("ill_valid", int'(valid), 0);
    checkOutput("ill_empty", int'(empty), 1);
    doReset();
    applyStimulus(1'b0, 1'b1, 5, 0);
    checkOutput("div_empty_valid", int'(valid), 0);
    doReset();
    applyStimulus(1'b0, 1'b1, 1, 0);
    checkOutput("pop_empty_valid", int'(valid), 0);
    push(9);
    push(10);
    checkOutput("sticky_empty", int'(empty), 1);
    checkOutput("sticky_valid", int'(valid), 0);

    // Reset priority over apply
    push(3);
    applyStimulus(1'b1, 1'b1, 0, 55);
    checkOutput("rst_prio_empty", int'(empty), 1);

    // Randomized phase
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int sel, o;
      bit r;
      r = ($urandom_range(0, 39) == 0);
      sel = $urandom_range(0, 19);
      if (sel < 9)       o = 0;
      else if (sel < 12) o = 1;
      else if (sel < 19) o = $urandom_range(2, 6);
      else               o = 7;
      applyStimulus(r, ($urandom_range(0, 4) != 0), o, $urandom_range(0, 255));
    end

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
